y_ifid_buffer: RTL and testbench

- Fetch/decode pipeline register with a 2-entry skid buffer, directly downstream of the instruction-fetch stage.
- Accepts each fetched instruction word with its PC+4 under a valid/ready handshake and presents it, in order, to the decode stage.
- Absorbs one cycle of decode back-pressure without dropping the word already in flight.
- Discards all buffered instructions on a control-flow flush (branch/jump redirect).

---
 rtl/y_ifid_buffer.sv | 138 +++++++++++++
 tb/tb_y_ifid_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y_ifid_buffer.sv
// Fetch/decode pipeline register with a 2-entry skid buffer (head H, skid S).
// Optional build macro IFID_PERF_EN adds saturating stall and flush counters.
module y_ifid_buffer #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] NOP_INS = XLEN'(32'h00000013)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_ins,
    input  logic [XLEN-1:0] in_pcp4,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_ins,
    output logic [XLEN-1:0] out_pcp4,
    output logic [XLEN-1:0] out_pc,
    output logic [1:0]      count
`ifdef IFID_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    // Occupancy doubles as the state: H valid in ONE/FULL, S valid only in FULL.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] h_ins_q, h_ins_d;
    logic [XLEN-1:0] h_pcp4_q, h_pcp4_d;
    logic [XLEN-1:0] s_ins_q, s_ins_d;
    logic [XLEN-1:0] s_pcp4_q, s_pcp4_d;

    logic h_valid;
    logic accept;
    logic pop;

    assign h_valid   = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_valid = h_valid;
    assign count     = state_q;
    assign accept    = in_valid & in_ready;
    assign pop       = h_valid & out_ready;

    assign out_ins  = h_valid ? h_ins_q : NOP_INS;
    assign out_pcp4 = h_valid ? h_pcp4_q : '0;
    assign out_pc   = h_valid ? (h_pcp4_q - XLEN'(4)) : '0;

    always_comb begin
        state_d  = state_q;
        h_ins_d  = h_ins_q;
        h_pcp4_d = h_pcp4_q;
        s_ins_d  = s_ins_q;
        s_pcp4_d = s_pcp4_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d  = ONE;
                        h_ins_d  = in_ins;
                        h_pcp4_d = in_pcp4;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        h_ins_d  = in_ins;
                        h_pcp4_d = in_pcp4;
                    end else if (accept) begin
                        state_d  = FULL;
                        s_ins_d  = in_ins;
                        s_pcp4_d = in_pcp4;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d  = ONE;
                        h_ins_d  = s_ins_q;
                        h_pcp4_d = s_pcp4_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            h_ins_q  <= '0;
            h_pcp4_q <= '0;
            s_ins_q  <= '0;
            s_pcp4_q <= '0;
        end else begin
            state_q  <= state_d;
            h_ins_q  <= h_ins_d;
            h_pcp4_q <= h_pcp4_d;
            s_ins_q  <= s_ins_d;
            s_pcp4_q <= s_pcp4_d;
        end
    end

`ifdef IFID_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [32:0] flush_sum;

    // Flush discards exactly the words currently held, i.e. the occupancy.
    assign flush_sum = {1'b0, flush_cnt_q} + 33'(count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush) begin
                flush_cnt_q <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_y_ifid_buffer.sv
// Scoreboard bench for y_ifid_buffer: directed stimulus pushes expected words,
// a negedge monitor pops and compares every word decode consumes.
module tb_y_ifid_buffer;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ins;
    logic [31:0] in_pcp4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pcp4;
    logic [31:0] out_pc;
    logic [1:0]  count;
`ifdef IFID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    y_ifid_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ins    (in_ins),
        .in_pcp4   (in_pcp4),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ins   (out_ins),
        .out_pcp4  (out_pcp4),
        .out_pc    (out_pc),
        .count     (count)
`ifdef IFID_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pcp4;
        logic [31:0] pc;
    } word_t;

    word_t exp_q[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a word that the bench knows will be accepted on the coming edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] pcp4);
        in_valid = 1'b1;
        in_ins   = ins;
        in_pcp4  = pcp4;
        exp_q.push_back('{ins: ins, pcp4: pcp4, pc: pcp4 - 32'd4});
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_ins   = 32'hDEAD_BEEF;
        in_pcp4  = 32'h0000_0BAD;
    endtask

    // Monitor: every consumed word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_ins, NOP);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("mon_ins", out_ins, w.ins);
                    check("mon_pcp4", out_pcp4, w.pcp4);
                    check("mon_pc", out_pc, w.pc);
                    $display("pop ins=%08h pcp4=%08h pc=%08h", out_ins, out_pcp4, out_pc);
                end
            end
            if (flush) exp_q.delete();
        end
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle_in();
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ins", out_ins, NOP);
        check("rst_out_pcp4", out_pcp4, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single word
        out_ready = 1'b1;
        send(32'h00000293, 32'd132);
        step();
        idle_in();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_ins", out_ins, 32'h00000293);
        check("single_pc", out_pc, 32'd128);
        check("single_count", 32'(count), 32'd1);
        step();
        check("single_drain_valid", 32'(out_valid), 32'd0);
        check("single_drain_ins", out_ins, NOP);

        // Back-pressure: A then B with decode stalled
        out_ready = 1'b0;
        send(32'hA0000001, 32'd132);
        step();
        check("bp_count1", 32'(count), 32'd1);
        send(32'hB0000002, 32'd136);
        step();
        idle_in();
        check("bp_count2", 32'(count), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head_a", out_ins, 32'hA0000001);
        step();
        check("bp_hold_count", 32'(count), 32'd2);
        check("bp_hold_ins", out_ins, 32'hA0000001);
        out_ready = 1'b1;
        step();
        check("bp_pop_count1", 32'(count), 32'd1);
        check("bp_head_b", out_ins, 32'hB0000002);
        step();
        check("bp_pop_count0", 32'(count), 32'd0);

        // Streaming: 11 words, no bubbles
        for (int i = 0; i < 11; i++) begin
            send(32'h00100013 + 32'(i << 7), 32'd132 + 32'(4 * i));
            check("stream_in_ready", 32'(in_ready), 32'd1);
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pcp4", out_pcp4, 32'd132 + 32'(4 * i));
        end
        idle_in();
        step();
        check("stream_end_count", 32'(count), 32'd0);

        // Flush while FULL with a new word presented (not accepted, not stored)
        out_ready = 1'b0;
        send(32'hC0000003, 32'd300);
        step();
        send(32'hD0000004, 32'd304);
        step();
        check("fl_full_count", 32'(count), 32'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ins   = 32'hE0000005;
        in_pcp4  = 32'd308;
        step();
        flush = 1'b0;
        idle_in();
        check("fl_count", 32'(count), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ins", out_ins, NOP);

        // Flush in ONE with a concurrent pop and a ready-side input
        send(32'hF0000006, 32'd400);
        step();
        idle_in();
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_ins    = 32'h60000007;
        in_pcp4   = 32'd404;
        check("fl1_in_ready", 32'(in_ready), 32'd1);
        step();
        flush = 1'b0;
        idle_in();
        check("fl1_count", 32'(count), 32'd0);
        step();
        check("fl1_no_ghost", 32'(out_valid), 32'd0);
`ifdef IFID_PERF_EN
        check("perf_flush_cnt", flush_cnt, 32'd3);
        check("perf_stall_cnt", stall_cnt, 32'd1);
`endif

        // Asynchronous reset between edges while FULL
        out_ready = 1'b0;
        send(32'h11111111, 32'd500);
        step();
        send(32'h22222222, 32'd504);
        step();
        idle_in();
        check("ar_full_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_count", 32'(count), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd1);
`ifdef IFID_PERF_EN
        check("ar_flush_cnt", flush_cnt, 32'd0);
`endif
        #3;
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        send(32'h33333333, 32'd200);
        step();
        idle_in();
        check("ar_first_head", out_pcp4, 32'd200);

        // Wrap-around of out_pc
        send(32'h44444444, 32'd0);
        step();
        idle_in();
        check("wrap_pc", out_pc, 32'hFFFFFFFC);
        step();
        step();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
